// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package divider_pkg;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   localparam int unsigned DefaultWidth = 8;

   // Iteration-counter width for an n-bit divider.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Two's-complement magnitude of a sign-extended value; callers truncate to N bits,
   // which keeps |-2^(N-1)| = 2^(N-1) representable as an unsigned N-bit value.
   function automatic logic [63:0] abs_mag(input logic [63:0] x);
      return x[63] ? (~x + 64'd1) : x;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
   parameter int unsigned N = 8
) (
   input  logic [N:0]   r,
   input  logic         bit_in,
   input  logic [N-1:0] dvsr,
   output logic [N:0]   r_next,
   output logic         q_bit
);

   logic [N+1:0] trial;

   always_comb begin
      trial  = {r, bit_in} - {2'b00, dvsr};
      q_bit  = ~trial[N+1];
      r_next = trial[N+1] ? {r[N-1:0], bit_in} : trial[N:0];
   end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider: N restoring iterations on magnitudes, then sign correction.
module signed_seq_divider
   import divider_pkg::*;
#(
   parameter int unsigned N = DefaultWidth
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int unsigned CntW = cnt_width(N);
   localparam logic [N-1:0] MinVal = {1'b1, {(N - 1){1'b0}}};

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N:0]      rem_q, rem_d;
   // Holds the dividend magnitude; quotient bits shift in as dividend bits shift out.
   logic [N-1:0]    shift_q, shift_d;
   logic [N-1:0]    dvsr_q, dvsr_d;
   logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic            dbz_q, dbz_d, ovf_q, ovf_d;
   logic [N-1:0]    quotient_q, quotient_d, remainder_q, remainder_d;
   logic            dbz_out_q, dbz_out_d, ovf_out_q, ovf_out_d;
   logic            done_q, done_d;

   logic [N:0]      step_r;
   logic            step_q;

   div_restore_step #(.N(N)) u_step (
      .r      (rem_q),
      .bit_in (shift_q[N-1]),
      .dvsr   (dvsr_q),
      .r_next (step_r),
      .q_bit  (step_q)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      shift_d     = shift_q;
      dvsr_d      = dvsr_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_out_d   = dbz_out_q;
      ovf_out_d   = ovf_out_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCalc;
               cnt_d   = '0;
               rem_d   = '0;
               shift_d = N'(abs_mag(64'($signed(dividend))));
               dvsr_d  = N'(abs_mag(64'($signed(divisor))));
               q_neg_d = dividend[N-1] ^ divisor[N-1];
               r_neg_d = dividend[N-1];
               dbz_d   = (divisor == '0);
               ovf_d   = (dividend == MinVal) && (divisor == '1);
            end
         end
         StCalc: begin
            rem_d   = step_r;
            shift_d = {shift_q[N-2:0], step_q};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(N - 1)) state_d = StFix;
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            // A zero divisor yields an all-ones quotient irrespective of sign.
            if (dbz_q)        quotient_d = '1;
            else if (q_neg_q) quotient_d = -shift_q;
            else              quotient_d = shift_q;
            remainder_d = r_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
            dbz_out_d   = dbz_q;
            ovf_out_d   = ovf_q;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         shift_q     <= '0;
         dvsr_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_out_q   <= 1'b0;
         ovf_out_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         shift_q     <= shift_d;
         dvsr_q      <= dvsr_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_out_q   <= dbz_out_d;
         ovf_out_q   <= ovf_out_d;
         done_q      <= done_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_out_q;
   assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Randomized and directed checks of signed_seq_divider at N=8 and N=16 against a / and % model.
module tb_signed_seq_divider;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic        start8 = 1'b0, busy8, done8, dbz8, ovf8;
   logic [7:0]  a8 = '0, b8 = '0, q8, r8;
   logic        start16 = 1'b0, busy16, done16, dbz16, ovf16;
   logic [15:0] a16 = '0, b16 = '0, q16, r16;

   exp_t exp8[$];
   exp_t exp16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   signed_seq_divider #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
      .div_by_zero(dbz8), .overflow(ovf8)
   );

   signed_seq_divider #(.N(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .dividend(a16), .divisor(b16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
      .div_by_zero(dbz16), .overflow(ovf16)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference: Verilog signed / and % on n-bit operands, plus the two special cases.
   function automatic exp_t model(input int n, input logic [15:0] ar, input logic [15:0] br);
      exp_t e;
      int a, b, mn;
      logic [15:0] mask;
      mask = (n == 8) ? 16'h00FF : 16'hFFFF;
      a  = (n == 8) ? int'($signed(ar[7:0])) : int'($signed(ar));
      b  = (n == 8) ? int'($signed(br[7:0])) : int'($signed(br));
      mn = -(1 << (n - 1));
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.due = 0;
      if (b == 0) begin
         e.dbz = 1'b1;
         e.q   = mask;
         e.r   = 16'(a) & mask;
      end else if (a == mn && b == -1) begin
         e.ovf = 1'b1;
         e.q   = 16'(mn) & mask;
         e.r   = '0;
      end else begin
         e.q = 16'(a / b) & mask;
         e.r = 16'(a % b) & mask;
      end
      return e;
   endfunction

   function automatic logic [15:0] pick(input int n);
      logic [15:0] v;
      case ($urandom_range(0, 9))
         0:       v = 16'h0000;
         1:       v = (n == 8) ? 16'h0080 : 16'h8000;
         2:       v = 16'hFFFF;
         3:       v = 16'(int'($urandom_range(1, 3)));
         default: v = 16'($urandom);
      endcase
      return (n == 8) ? (v & 16'h00FF) : v;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int g = 0;
      while (busy8 && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (busy8) chk("issue8_busy_timeout", {31'b0, busy8}, 0);
      start8 = 1'b1;
      a8 = a;
      b8 = b;
      e = model(8, {8'h00, a}, {8'h00, b});
      e.due = cyc + 10;
      exp8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int g = 0;
      while (busy16 && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (busy16) chk("issue16_busy_timeout", {31'b0, busy16}, 0);
      start16 = 1'b1;
      a16 = a;
      b16 = b;
      e = model(16, a, b);
      e.due = cyc + 18;
      exp16.push_back(e);
      @(negedge clk);
      start16 = 1'b0;
   endtask

   task automatic wait_done8();
      int g = 0;
      while (!done8 && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("wait_done8", {31'b0, done8}, 1);
   endtask

   task automatic lit8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf);
      issue8(a, b);
      wait_done8();
      chk({name, "_q"}, {24'b0, q8}, {24'b0, eq});
      chk({name, "_r"}, {24'b0, r8}, {24'b0, er});
      chk({name, "_dbz"}, {31'b0, dbz8}, {31'b0, edbz});
      chk({name, "_ovf"}, {31'b0, ovf8}, {31'b0, eovf});
   endtask

   // Compare process: every done must match the oldest outstanding request, on time.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done8) begin
            if (exp8.size() == 0) begin
               chk("done8_unexpected", {31'b0, done8}, 0);
            end else begin
               e = exp8.pop_front();
               chk("lat8", cyc, e.due);
               chk("q8", {16'b0, 8'b0, q8}, {16'b0, e.q});
               chk("r8", {16'b0, 8'b0, r8}, {16'b0, e.r});
               chk("dbz8", {31'b0, dbz8}, {31'b0, e.dbz});
               chk("ovf8", {31'b0, ovf8}, {31'b0, e.ovf});
            end
         end else if (exp8.size() > 0 && cyc > exp8[0].due) begin
            chk("done8_missing", {31'b0, done8}, 1);
            void'(exp8.pop_front());
         end
         if (done16) begin
            if (exp16.size() == 0) begin
               chk("done16_unexpected", {31'b0, done16}, 0);
            end else begin
               e = exp16.pop_front();
               chk("lat16", cyc, e.due);
               chk("q16", {16'b0, q16}, {16'b0, e.q});
               chk("r16", {16'b0, r16}, {16'b0, e.r});
               chk("dbz16", {31'b0, dbz16}, {31'b0, e.dbz});
               chk("ovf16", {31'b0, ovf16}, {31'b0, e.ovf});
            end
         end else if (exp16.size() > 0 && cyc > exp16[0].due) begin
            chk("done16_missing", {31'b0, done16}, 1);
            void'(exp16.pop_front());
         end
      end
   end

   initial begin
      exp_t m;
      int g;

      m = model(8, 16'd100, 16'd7);
      chk("model_100_7_q", {16'b0, m.q}, 32'd14);
      chk("model_100_7_r", {16'b0, m.r}, 32'd2);
      m = model(8, 16'h009C, 16'd7);
      chk("model_n100_7_q", {16'b0, m.q}, 32'h00F2);
      chk("model_n100_7_r", {16'b0, m.r}, 32'h00FE);
      m = model(16, 16'h8000, 16'hFFFF);
      chk("model_ovf16_q", {16'b0, m.q}, 32'h8000);
      chk("model_ovf16_flag", {31'b0, m.ovf}, 1);
      m = model(8, 16'd37, 16'd0);
      chk("model_dbz_q", {16'b0, m.q}, 32'h00FF);
      chk("model_dbz_r", {16'b0, m.r}, 32'd37);

      repeat (3) @(negedge clk);
      chk("rst_q8", {24'b0, q8}, 0);
      chk("rst_r8", {24'b0, r8}, 0);
      chk("rst_done8", {31'b0, done8}, 0);
      chk("rst_busy8", {31'b0, busy8}, 0);
      chk("rst_flags8", {30'b0, dbz8, ovf8}, 0);
      chk("rst_q16", {16'b0, q16}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      lit8("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
      lit8("dn100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
      lit8("d100_n7", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 1'b0);
      lit8("dn100_n7", 8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, 1'b0);
      lit8("dmin_n1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 1'b1);
      lit8("dmin_1", 8'h80, 8'd1, 8'h80, 8'd0, 1'b0, 1'b0);
      lit8("d37_0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1'b0);
      lit8("dn37_0", 8'hDB, 8'd0, 8'hFF, 8'hDB, 1'b1, 1'b0);

      // start during CALC is ignored; then a back-to-back request in the done cycle
      issue8(8'd100, 8'd7);
      repeat (3) @(negedge clk);
      start8 = 1'b1;
      a8 = 8'hCE;
      b8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8();
      chk("ignored_q", {24'b0, q8}, 32'd14);
      chk("ignored_r", {24'b0, r8}, 32'd2);
      chk("done_cycle_busy", {31'b0, busy8}, 0);
      issue8(8'd20, 8'hFD);
      wait_done8();
      chk("b2b_q", {24'b0, q8}, 32'h00FA);
      chk("b2b_r", {24'b0, r8}, 32'd2);

      // Reset mid-CALC aborts silently
      issue8(8'd77, 8'd5);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      exp8.delete();
      #1;
      chk("abort_q8", {24'b0, q8}, 0);
      chk("abort_r8", {24'b0, r8}, 0);
      chk("abort_busy8", {31'b0, busy8}, 0);
      chk("abort_done8", {31'b0, done8}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lit8("after_rst", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0);

      fork
         begin
            repeat (3000) issue8(pick(8) & 8'hFF, pick(8) & 8'hFF);
         end
         begin
            repeat (1600) issue16(pick(16), pick(16));
         end
      join

      g = 0;
      while ((exp8.size() != 0 || exp16.size() != 0) && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("drain8", exp8.size(), 0);
      chk("drain16", exp16.size(), 0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
